// File: rtl/register_file_mp_if.sv
// Bus for the multi-port register file: one write port, two read ports that
// share one enable, plus the read-valid and busy flags.
interface register_file_mp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              re;
  logic [ADDR_W-1:0] ri_a;
  logic [ADDR_W-1:0] ri_b;
  logic              we;
  logic [ADDR_W-1:0] ri_d;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rd_valid;
  logic              busy;

  modport master (
    output re, ri_a, ri_b, we, ri_d, d,
    input  a, b, rd_valid, busy
  );

  modport slave (
    input  re, ri_a, ri_b, we, ri_d, d,
    output a, b, rd_valid, busy
  );
endinterface

// File: rtl/register_file_mp.sv
// 2R/1W register file with optional write->read bypass and hardwired-zero r0.
// After reset, a clear sequencer zeroes one entry per cycle while busy is high.
module register_file_mp_rport #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] bank,
  input  logic [ADDR_W-1:0]                  idx,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_idx,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rdata
);
  always_comb begin
    rdata = bank[idx];
    if (BYPASS != 0 && wr_en && wr_idx == idx) rdata = wr_data;
    // r0 reads zero even when a same-cycle write to it would be forwarded
    if (ZERO_REG != 0 && idx == '0) rdata = '0;
  end
endmodule

module register_file_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input logic              clk,
  input logic              rst,
  register_file_mp_if.slave bus
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NUM_RP = 2;

  typedef enum logic { INIT, READY } state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               ptr_q, ptr_d;
  logic                            busy_q, busy_d;
  logic                            vld_q, vld_d;
  logic [NUM_RP-1:0][DATA_W-1:0]   rdat_q, rdat_d;
  logic [DEPTH-1:0][DATA_W-1:0]    bank_q;

  logic                            wr_en;
  logic [ADDR_W-1:0]               wr_idx;
  logic [DATA_W-1:0]               wr_data;
  logic [NUM_RP-1:0][ADDR_W-1:0]   rd_idx;
  logic [NUM_RP-1:0][DATA_W-1:0]   rd_data;

  assign rd_idx = {bus.ri_b, bus.ri_a};

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
    register_file_mp_rport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rp (
      .bank   (bank_q),
      .idx    (rd_idx[p]),
      .wr_en  (wr_en),
      .wr_idx (wr_idx),
      .wr_data(wr_data),
      .rdata  (rd_data[p])
    );
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    rdat_d  = rdat_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = '0;
    case (state_q)
      INIT: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        if (bus.we && !(ZERO_REG != 0 && bus.ri_d == '0)) begin
          wr_en   = 1'b1;
          wr_idx  = bus.ri_d;
          wr_data = bus.d;
        end
        if (bus.re) begin
          rdat_d = rd_data;
          vld_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      vld_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      rdat_q  <= rdat_d;
    end
  end

  // Array contents are left alone on a reset edge; the sequencer clears them after
  always_ff @(posedge clk) begin
    if (!rst && wr_en) bank_q[wr_idx] <= wr_data;
  end

  assign bus.a        = rdat_q[0];
  assign bus.b        = rdat_q[1];
  assign bus.rd_valid = vld_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: three instances (bypass, no bypass, zero-reg) driven by the
// same stimulus, each checked against hand-computed expectations.
module tb_register_file_mp;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       re = 1'b0, we = 1'b0;
  logic [2:0] ri_a = '0, ri_b = '0, ri_d = '0;
  logic [7:0] d = '0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_W(8), .ADDR_W(3)) if0 ();
  register_file_mp_if #(.DATA_W(8), .ADDR_W(3)) if1 ();
  register_file_mp_if #(.DATA_W(8), .ADDR_W(3)) if2 ();

  assign if0.re = re;  assign if0.ri_a = ri_a; assign if0.ri_b = ri_b;
  assign if0.we = we;  assign if0.ri_d = ri_d; assign if0.d = d;
  assign if1.re = re;  assign if1.ri_a = ri_a; assign if1.ri_b = ri_b;
  assign if1.we = we;  assign if1.ri_d = ri_d; assign if1.d = d;
  assign if2.re = re;  assign if2.ri_a = ri_a; assign if2.ri_b = ri_b;
  assign if2.we = we;  assign if2.ri_d = ri_d; assign if2.d = d;

  register_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0))
    u_byp (.clk(clk), .rst(rst), .bus(if0.slave));
  register_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0))
    u_nobyp (.clk(clk), .rst(rst), .bus(if1.slave));
  register_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1))
    u_zero (.clk(clk), .rst(rst), .bus(if2.slave));

  logic [7:0] a_o [3];
  logic [7:0] b_o [3];
  logic       v_o [3];
  logic       busy_o [3];
  assign a_o[0] = if0.a; assign b_o[0] = if0.b; assign v_o[0] = if0.rd_valid; assign busy_o[0] = if0.busy;
  assign a_o[1] = if1.a; assign b_o[1] = if1.b; assign v_o[1] = if1.rd_valid; assign busy_o[1] = if1.busy;
  assign a_o[2] = if2.a; assign b_o[2] = if2.b; assign v_o[2] = if2.rd_valid; assign busy_o[2] = if2.busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [7:0] val);
    we = 1'b1; ri_d = idx; d = val;
    tick();
    we = 1'b0;
  endtask

  // Pulse rst for one edge, then count edges until every instance drops busy.
  task automatic test_reset(input string tag);
    int t;
    int fall [3];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (busy_o[k] !== 1'b1 || a_o[k] !== 8'h00 || b_o[k] !== 8'h00 || v_o[k] !== 1'b0) begin
        n_err++;
        $display("FAIL %s reset_state dut%0d: busy=%b a=%h b=%h v=%b, need busy=1 a=00 b=00 v=0",
                 tag, k, busy_o[k], a_o[k], b_o[k], v_o[k]);
      end
      fall[k] = -1;
    end
    t = 0;
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && t < 20) begin
      tick();
      t++;
      for (int k = 0; k < 3; k++) begin
        if (fall[k] < 0 && busy_o[k] === 1'b0) fall[k] = t;
        n_cmp++;
        if (v_o[k] !== 1'b0) begin
          n_err++;
          $display("FAIL %s init_rd_valid dut%0d edge %0d: got %b, need 0", tag, k, t, v_o[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (fall[k] !== 8) begin
        n_err++;
        $display("FAIL %s busy_len dut%0d: busy fell after %0d edges, need 8", tag, k, fall[k]);
      end
    end
  endtask

  task automatic test_init_clear();
    re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ri_a = 3'(i); ri_b = 3'(7 - i);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (a_o[k] !== 8'h00 || b_o[k] !== 8'h00 || v_o[k] !== 1'b1) begin
          n_err++;
          $display("FAIL init_clear dut%0d idx %0d: a=%h b=%h v=%b, need a=00 b=00 v=1",
                   k, i, a_o[k], b_o[k], v_o[k]);
        end
      end
    end
    re = 1'b0;
  endtask

  task automatic test_write_read();
    do_write(3'd5, 8'hA7);
    re = 1'b1; ri_a = 3'd5; ri_b = 3'd3;
    tick();
    re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== 8'hA7 || b_o[k] !== 8'h00 || v_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL write_read dut%0d: a=%h b=%h v=%b, need a=a7 b=00 v=1", k, a_o[k], b_o[k], v_o[k]);
      end
    end
    ri_a = 3'd0; ri_b = 3'd1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== 8'hA7 || b_o[k] !== 8'h00 || v_o[k] !== 1'b0) begin
        n_err++;
        $display("FAIL read_hold dut%0d: a=%h b=%h v=%b, need a=a7 b=00 v=0", k, a_o[k], b_o[k], v_o[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_same [3];
    exp_same[0] = 8'h3C; exp_same[1] = 8'h11; exp_same[2] = 8'h3C;
    do_write(3'd2, 8'h11);
    we = 1'b1; ri_d = 3'd2; d = 8'h3C;
    re = 1'b1; ri_a = 3'd2; ri_b = 3'd2;
    tick();
    we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== exp_same[k] || b_o[k] !== exp_same[k] || v_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL bypass_same_cycle dut%0d: a=%h b=%h v=%b, need a=b=%h v=1",
                 k, a_o[k], b_o[k], v_o[k], exp_same[k]);
      end
    end
    tick();
    re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== 8'h3C || b_o[k] !== 8'h3C || v_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL bypass_commit dut%0d: a=%h b=%h v=%b, need a=b=3c v=1", k, a_o[k], b_o[k], v_o[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [7:0] exp_rd [3];
    logic [7:0] exp_wr [3];
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00;
    exp_wr[0] = 8'h5A; exp_wr[1] = 8'hFF; exp_wr[2] = 8'h00;
    do_write(3'd0, 8'hFF);
    re = 1'b1; ri_a = 3'd0; ri_b = 3'd5;
    tick();
    re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== exp_rd[k] || b_o[k] !== 8'hA7) begin
        n_err++;
        $display("FAIL zero_read dut%0d: a=%h b=%h, need a=%h b=a7", k, a_o[k], b_o[k], exp_rd[k]);
      end
    end
    we = 1'b1; ri_d = 3'd0; d = 8'h5A;
    re = 1'b1; ri_a = 3'd0; ri_b = 3'd0;
    tick();
    we = 1'b0; re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== exp_wr[k] || b_o[k] !== exp_wr[k]) begin
        n_err++;
        $display("FAIL zero_wr_rd dut%0d: a=%h b=%h, need a=b=%h", k, a_o[k], b_o[k], exp_wr[k]);
      end
    end
  endtask

  // Second reset is re-asserted on the 4th INIT edge and must restart the count.
  task automatic test_reset_mid();
    do_write(3'd7, 8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (busy_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL mid_init_busy dut%0d: busy=%b, need 1", k, busy_o[k]);
      end
    end
    test_reset("reset_mid");
    re = 1'b1; ri_a = 3'd7; ri_b = 3'd2;
    tick();
    re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== 8'h00 || b_o[k] !== 8'h00 || v_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_clear dut%0d: a=%h b=%h v=%b, need a=00 b=00 v=1", k, a_o[k], b_o[k], v_o[k]);
      end
    end
  endtask

  task automatic test_busy_mask();
    do_write(3'd1, 8'h42);
    we = 1'b1; ri_d = 3'd1; d = 8'h99;
    re = 1'b1; ri_a = 3'd1; ri_b = 3'd1;
    test_reset("busy_mask");
    we = 1'b0;
    tick();
    re = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (a_o[k] !== 8'h00 || b_o[k] !== 8'h00 || v_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL busy_mask_r1 dut%0d: a=%h b=%h v=%b, need a=00 b=00 v=1", k, a_o[k], b_o[k], v_o[k]);
      end
    end
  endtask

  initial begin
    test_reset("reset");
    test_init_clear();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_reset_mid();
    test_busy_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
